// File: rtl/key_pkg.sv
// Shared types and default timing for the multi-channel key front end.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } key_state_e;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DB_MS       = 20;
    localparam int LONG_MS     = 1000;

    localparam int DEF_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DB_MS;
    localparam int DEF_LONG_CYCLES     = CLK_FREQ_HZ / 1000 * LONG_MS;

    // Width able to hold 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Raw key pins and per-channel debounced level, event strobes and toggle state.
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] click_pulse;
    logic [N_KEYS-1:0] toggle_out;

    modport master (
        output key,
        input  key_level, press_pulse, release_pulse, long_pulse, click_pulse, toggle_out
    );

    modport slave (
        input  key,
        output key_level, press_pulse, release_pulse, long_pulse, click_pulse, toggle_out
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stable-time debounce, event FSM, toggle.
//   state     | meaning
//   IDLE      | key released, waiting for a debounced press
//   PRESSED   | key held, hold_cnt running towards the long threshold
//   LONG_HELD | long_pulse already fired, waiting for release
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int TOGGLE_MODE     = 0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic click_pulse,
    output logic toggle_out
);

    localparam int DBW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW  = cnt_width(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [1:0]     sync_q, sync_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           level_q, level_d;
    key_state_e     state_q, state_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           long_q, long_d;
    logic           click_q, click_d;
    logic           toggle_q, toggle_d;
    logic           key_s, level_rise, level_fall, toggle_evt;

    always_comb begin
        sync_d   = {sync_q[0], key_n};
        key_s    = ~sync_q[1];
        db_cnt_d = '0;
        level_d  = level_q;
        // Any cycle where the synchronised pin agrees with the level restarts the count.
        if (key_s != level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                level_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
        level_rise = level_d & ~level_q;
        level_fall = ~level_d & level_q;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        click_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_rise) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over a coincident long threshold.
                if (level_fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            LONG_HELD: begin
                if (level_fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        toggle_evt = (TOGGLE_MODE == 0) ? press_q : click_q;
        toggle_d   = toggle_q ^ toggle_evt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q     <= 2'b11;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            state_q    <= IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            click_q    <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            click_q    <= click_d;
            toggle_q   <= toggle_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign click_pulse   = click_q;
    assign toggle_out    = toggle_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key front end: N_KEYS fully independent debounce/event channels.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int TOGGLE_MODE     = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    key_debounce_multi_if.slave   kif
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .TOGGLE_MODE     (TOGGLE_MODE)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst       (sys_rst),
            .key_n         (kif.key[i]),
            .key_level     (kif.key_level[i]),
            .press_pulse   (kif.press_pulse[i]),
            .release_pulse (kif.release_pulse[i]),
            .long_pulse    (kif.long_pulse[i]),
            .click_pulse   (kif.click_pulse[i]),
            .toggle_out    (kif.toggle_out[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Randomised bench for key_debounce_multi: two DUTs (toggle modes 0 and 1) share the
// pins; a pin-history reference model feeds an event scoreboard checked by a monitor.
module tb_key_debounce_multi;

    localparam int N    = 2;
    localparam int D    = 10;
    localparam int L    = 50;
    localparam int MAXC = 32768;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pins = '1;

    always #10 clk = ~clk;

    key_debounce_multi_if #(.N_KEYS(N)) if0 ();
    key_debounce_multi_if #(.N_KEYS(N)) if1 ();
    assign if0.key = pins;
    assign if1.key = pins;

    key_debounce_multi #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .TOGGLE_MODE(0))
        dut0 (.sys_clk(clk), .sys_rst(rst), .kif(if0.slave));
    key_debounce_multi #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .TOGGLE_MODE(1))
        dut1 (.sys_clk(clk), .sys_rst(rst), .kif(if1.slave));

    // kind: 0 press, 1 release, 2 long, 3 click
    typedef struct {
        int cyc;
        int dut;
        int ch;
        int kind;
    } ev_t;

    ev_t sbq[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;

    // Reference state: pin value driven during each cycle, and the event-level view.
    bit hist [N][MAXC];
    int last_rst = -1000;
    bit lvl [N];
    int press_t [N];
    bit long_done [N];
    bit tog0 [N];
    bit tog1 [N];
    bit pr_prev [N];
    bit ck_prev [N];

    // Pins are seen as released for every cycle up to a reset (synchroniser preset).
    function automatic bit h(input int c, input int i);
        if (i < 0 || i <= last_rst - 1 || i >= MAXC) return 1'b1;
        return hist[c][i];
    endfunction

    task automatic push_ev(input int t, input int c, input int k);
        for (int d = 0; d < 2; d++) sbq.push_back('{t, d, c, k});
    endtask

    // A level is accepted once the pin has held one value for D driven cycles; the
    // two synchroniser stages put that window 2 cycles behind the current edge.
    always @(posedge clk) begin
        bit first, same, pressed, pr, rl, lg, ck;
        cyc = cyc + 1;
        if (rst) begin
            last_rst = cyc;
            for (int c = 0; c < N; c++) begin
                lvl[c] = 1'b0; long_done[c] = 1'b1;
                pr_prev[c] = 1'b0; ck_prev[c] = 1'b0;
                tog0[c] = 1'b0; tog1[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (cyc - 1 < MAXC) hist[c][cyc-1] = pins[c];
                if (pr_prev[c]) tog0[c] = ~tog0[c];
                if (ck_prev[c]) tog1[c] = ~tog1[c];
                first = h(c, cyc - 2 - D);
                same  = 1'b1;
                for (int k = cyc - 1 - D; k <= cyc - 3; k++)
                    if (h(c, k) != first) same = 1'b0;
                pressed = ~first;
                pr = 1'b0; rl = 1'b0; lg = 1'b0; ck = 1'b0;
                if (same && pressed != lvl[c]) begin
                    lvl[c] = pressed;
                    if (pressed) begin
                        pr = 1'b1; press_t[c] = cyc; long_done[c] = 1'b0;
                    end else begin
                        rl = 1'b1; ck = ~long_done[c]; long_done[c] = 1'b1;
                    end
                end else if (lvl[c] && !long_done[c] && (cyc - press_t[c] == L)) begin
                    lg = 1'b1; long_done[c] = 1'b1;
                end
                if (pr) push_ev(cyc, c, 0);
                if (rl) push_ev(cyc, c, 1);
                if (lg) push_ev(cyc, c, 2);
                if (ck) push_ev(cyc, c, 3);
                pr_prev[c] = pr;
                ck_prev[c] = ck;
            end
        end
    end

    // Monitor: sample on the falling edge, pop the events due this cycle and compare.
    always @(negedge clk) begin
        logic [4*N-1:0] exp_v [2];
        logic [4*N-1:0] act_v [2];
        logic [2*N-1:0] exp_s, act_s;
        ev_t e;
        if (cyc > 0) begin
            exp_v[0] = '0;
            exp_v[1] = '0;
            while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                exp_v[e.dut][e.ch*4 + e.kind] = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                act_v[0][c*4+0] = if0.press_pulse[c];
                act_v[0][c*4+1] = if0.release_pulse[c];
                act_v[0][c*4+2] = if0.long_pulse[c];
                act_v[0][c*4+3] = if0.click_pulse[c];
                act_v[1][c*4+0] = if1.press_pulse[c];
                act_v[1][c*4+1] = if1.release_pulse[c];
                act_v[1][c*4+2] = if1.long_pulse[c];
                act_v[1][c*4+3] = if1.click_pulse[c];
            end
            for (int d = 0; d < 2; d++) begin
                if (exp_v[d] != '0 || act_v[d] !== '0) begin
                    compared++;
                    if (act_v[d] !== exp_v[d]) begin
                        mismatched++;
                        $display("FAIL pulses dut%0d cyc %0d: got %b expected %b", d, cyc, act_v[d], exp_v[d]);
                    end
                end
                for (int c = 0; c < N; c++) begin
                    exp_s[c]     = lvl[c];
                    exp_s[N + c] = (d == 0) ? tog0[c] : tog1[c];
                end
                act_s = (d == 0) ? {if0.toggle_out, if0.key_level} : {if1.toggle_out, if1.key_level};
                compared++;
                if (act_s !== exp_s) begin
                    mismatched++;
                    $display("FAIL level_toggle dut%0d cyc %0d: got %b expected %b", d, cyc, act_s, exp_s);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        int r;
        rst = 1'b1; pins = '1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(100);

        // Bounce on key 0, then a clean hold.
        for (int i = 0; i < 2; i++) begin
            pins[0] = 1'b0; wait_cyc(2);
            pins[0] = 1'b1; wait_cyc(2);
        end
        pins[0] = 1'b0; wait_cyc(40);
        pins[0] = 1'b1; wait_cyc(30);

        // Short click.
        pins[0] = 1'b0; wait_cyc(30);
        pins[0] = 1'b1; wait_cyc(30);

        // Long press on key 1.
        pins[1] = 1'b0; wait_cyc(120);
        pins[1] = 1'b1; wait_cyc(30);

        // Release one before, exactly at, and one after the long threshold.
        for (int hold = L - 1; hold <= L + 1; hold++) begin
            pins[1] = 1'b0; wait_cyc(hold);
            pins[1] = 1'b1; wait_cyc(30);
        end

        // Glitches one short of and exactly the debounce time.
        pins[0] = 1'b0; wait_cyc(D - 1);
        pins[0] = 1'b1; wait_cyc(30);
        pins[0] = 1'b0; wait_cyc(D);
        pins[0] = 1'b1; wait_cyc(30);

        // Reset while key 0 is held, key stays held afterwards.
        pins[0] = 1'b0; wait_cyc(30);
        rst = 1'b1; wait_cyc(3);
        rst = 1'b0; wait_cyc(40);
        pins[0] = 1'b1; wait_cyc(30);

        // Random pin patterns, mixed glitch/short/long durations, occasional reset.
        repeat (150) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b1; wait_cyc($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                pins = N'($urandom_range(0, (1 << N) - 1));
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(13, 130);
                wait_cyc(len);
            end
        end

        pins = '1;
        wait_cyc(D + 20);
        @(negedge clk);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_events: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel key front end. It is the successor to the single-key debounce/beep-toggle path. Each of N_KEYS active-low mechanical key inputs is synchronised, debounced with a stable-time counter, and classified into press, release, long-press and short-click events. A per-channel toggle output drives beep/LED-style loads directly, and the event pulses feed downstream control logic.

Parameters:
N_KEYS, 4, number of independent key channels (1..16)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable sys_clk cycles before a level change is accepted (20 ms at 50 MHz); minimum 2
LONG_CYCLES, 50_000_000, pressed cycles, counted from the debounced press, before long_pulse fires (1 s at 50 MHz); must be > DEBOUNCE_CYCLES
TOGGLE_MODE, 0, 0 = toggle_out flips on every debounced press; 1 = toggle_out flips only on a short click (release before long threshold)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  reset, synchronous, active-high
key  in  N_KEYS  raw key pins, active-low (0 = pressed), asynchronous to sys_clk
key_level  out  N_KEYS  debounced key state, 1 = pressed
press_pulse  out  N_KEYS  1-cycle strobe on debounced press
release_pulse  out  N_KEYS  1-cycle strobe on debounced release
long_pulse  out  N_KEYS  1-cycle strobe when held for LONG_CYCLES
click_pulse  out  N_KEYS  1-cycle strobe on release that occurs before long_pulse fired
toggle_out  out  N_KEYS  per-channel toggle state (e.g. beep enable)

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the sys_clk rising edge; sys_rst is sampled only there.
- Reset values:
  - Synchroniser flops = 1 (released).
  - All outputs = 0.
  - All counters = 0.
  - FSM = IDLE.
  - Reset asserted mid-press or mid-debounce aborts with no pulses. After release of reset, a key physically held is seen as a fresh press after the normal latency.
- Synchroniser: 2 flops per channel. key_s is the inverted second stage (1 = pressed).
- Debounce, per channel:
  - db_cnt increments each cycle key_s != key_level.
  - db_cnt clears to 0 on any cycle key_s == key_level (a bounce restarts the count).
  - When db_cnt == DEBOUNCE_CYCLES-1 and the mismatch persists, key_level flips next edge and db_cnt clears.
  - Latency: a clean pin edge is followed by key_level change exactly 2 + DEBOUNCE_CYCLES cycles later.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change key_level.
- FSM per channel, states IDLE, PRESSED, LONG_HELD:
  - IDLE -> PRESSED on key_level rising. press_pulse asserts in the same cycle key_level first reads 1. hold_cnt is cleared.
  - PRESSED: hold_cnt increments each cycle. When it reaches LONG_CYCLES-1, go to LONG_HELD and assert long_pulse, i.e. LONG_CYCLES cycles after press_pulse.
  - PRESSED -> IDLE on key_level falling: release_pulse and click_pulse both assert.
  - LONG_HELD -> IDLE on key_level falling: release_pulse only. hold_cnt stops (no wrap). long_pulse fires at most once per press.
- Simultaneous events: if release occurs in the same cycle the long threshold is reached, release wins. Result is IDLE with release_pulse + click_pulse, and no long_pulse.
- toggle_out:
  - TOGGLE_MODE 0: inverts in the cycle after press_pulse.
  - TOGGLE_MODE 1: inverts in the cycle after click_pulse.
- Pulses are registered outputs, never combinational from key. Channels are fully independent; simultaneous presses on all channels are legal.
- Counter widths: $clog2(DEBOUNCE_CYCLES) and $clog2(LONG_CYCLES). Both saturate rather than wrap.

Decomposition:
- Shared package key_pkg: FSM state enum (IDLE, PRESSED, LONG_HELD), default timing constants CLK_FREQ_HZ = 50_000_000, DB_MS = 20, LONG_MS = 1000.
- Sub-module key_debounce_ch: one channel containing synchroniser, debounce, FSM and toggle. The top is a generate loop over N_KEYS.

Test Plan:
- Sim parameters: DEBOUNCE_CYCLES=10, LONG_CYCLES=50, N_KEYS=2, 20 ns clock.
- Reset: hold key=2'b11, sys_rst=1 for 3 cycles, release -> all outputs 0, no pulses for 100 cycles.
- Bounce: key[0] toggles 0/1 every 2 cycles for 8 cycles, then holds 0 -> key_level[0] rises exactly 12 cycles after the last edge, with a single press_pulse. toggle_out[0] becomes 1 (TOGGLE_MODE 0).
- Short click: press key[0] 30 cycles, release cleanly -> press_pulse, then release_pulse + click_pulse; no long_pulse.
- Long press: hold key[1]=0 for 120 cycles -> long_pulse[1] exactly 50 cycles after press_pulse[1] and only once. Release gives release_pulse without click_pulse.
- TOGGLE_MODE 1: one click, then one long press -> toggle_out goes 0->1 after the click and stays 1 after the long press.
- Mid-press reset: assert sys_rst while key[0] is held in PRESSED -> outputs clear next edge. After deassert with key still 0 -> new press_pulse 12 cycles later.
